// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider: one quotient bit per clock, start/done handshake.
// Results are registered on entry to DONE and held until the next result.
module seq_divider #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] q_work_q, q_work_d;
    logic [WIDTH-1:0] d_work_q, d_work_d;
    logic [WIDTH:0]   r_work_q, r_work_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH:0]   r_shift;
    logic [WIDTH:0]   r_trial;
    logic [WIDTH-1:0] q_shift;

    // Partial remainder always stays below the divisor, so its top bit is free
    // to absorb the shift and act as the trial-subtraction sign.
    always_comb begin
        r_shift = {r_work_q[WIDTH-1:0], q_work_q[WIDTH-1]};
        q_shift = {q_work_q[WIDTH-2:0], 1'b0};
        r_trial = r_shift - {1'b0, d_work_q};
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        q_work_d = q_work_q;
        d_work_d = d_work_q;
        r_work_d = r_work_q;
        quot_d   = quot_q;
        rem_d    = rem_q;
        dbz_d    = dbz_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    q_work_d = dividend;
                    d_work_d = divisor;
                    r_work_d = '0;
                    if (divisor != '0) begin
                        cnt_d   = CW'(WIDTH);
                        state_d = RUN;
                    end else begin
                        cnt_d   = '0;
                        quot_d  = '1;
                        rem_d   = dividend;
                        dbz_d   = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            RUN: begin
                if (!r_trial[WIDTH]) begin
                    r_work_d = r_trial;
                    q_work_d = q_shift | WIDTH'(1);
                end else begin
                    r_work_d = r_shift;
                    q_work_d = q_shift;
                end
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    quot_d  = q_work_d;
                    rem_d   = r_work_d[WIDTH-1:0];
                    dbz_d   = 1'b0;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            q_work_q <= '0;
            d_work_q <= '0;
            r_work_q <= '0;
            quot_q   <= '0;
            rem_q    <= '0;
            dbz_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            q_work_q <= q_work_d;
            d_work_q <= d_work_d;
            r_work_q <= r_work_d;
            quot_q   <= quot_d;
            rem_q    <= rem_d;
            dbz_q    <= dbz_d;
        end
    end

    assign busy        = (state_q != IDLE);
    assign done        = (state_q == DONE);
    assign quotient    = quot_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider (WIDTH=8): expected results are queued
// when an operation is issued and popped when done is observed.
module tb_seq_divider;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] dividend;
    logic [7:0] divisor;
    logic       busy;
    logic       done;
    logic [7:0] quotient;
    logic [7:0] remainder;
    logic       div_by_zero;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int accept_cyc = 0;

    typedef struct {
        logic [7:0] dvd;
        logic [7:0] dvs;
        logic [7:0] q;
        logic [7:0] r;
        logic       dbz;
    } exp_t;

    exp_t sb[$];

    seq_divider #(.WIDTH(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .dividend   (dividend),
        .divisor    (divisor),
        .busy       (busy),
        .done       (done),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic push_exp(input logic [7:0] a, input logic [7:0] b);
        exp_t e;
        e.dvd = a;
        e.dvs = b;
        if (b == 8'd0) begin
            e.q = 8'hFF; e.r = a; e.dbz = 1'b1;
        end else begin
            e.q = a / b; e.r = a % b; e.dbz = 1'b0;
        end
        sb.push_back(e);
    endtask

    // Called at a negedge while idle; returns at the negedge after the accepting edge.
    task automatic start_op(input logic [7:0] a, input logic [7:0] b);
        start = 1'b1;
        dividend = a;
        divisor = b;
        push_exp(a, b);
        @(posedge clk);
        #1 accept_cyc = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(output bit got, output int lat);
        got = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (done === 1'b1) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        lat = cyc - accept_cyc;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; dividend = 8'd100; divisor = 8'd7;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done, div_by_zero} !== 3'b000)
            $display("FAIL reset_flags: busy/done/dbz=%b required 000", {busy, done, div_by_zero});
        checks++;
        if (quotient !== 8'd0 || remainder !== 8'd0)
            $display("FAIL reset_data: q=%0d r=%0d required 0 0", quotient, remainder);
        if ({busy, done, div_by_zero} !== 3'b000 || quotient !== 8'd0 || remainder !== 8'd0) begin
            errors++;
            if ({busy, done, div_by_zero} !== 3'b000 && (quotient !== 8'd0 || remainder !== 8'd0)) errors++;
        end
        start = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: busy=%b required 0", busy);
        end
    endtask

    task automatic test_basic();
        bit got; int lat; exp_t e;
        start_op(8'd100, 8'd7);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL basic_busy: busy=%b required 1", busy);
        end
        wait_done(got, lat);
        e = sb.pop_front();
        checks++;
        if (!got || lat != 8) begin
            errors++;
            $display("FAIL basic_latency: got=%0d lat=%0d required 1 8", got, lat);
        end
        checks++;
        if (quotient !== e.q || remainder !== e.r || div_by_zero !== e.dbz) begin
            errors++;
            $display("FAIL basic_result: %0d/%0d gave q=%0d r=%0d dbz=%b required q=%0d r=%0d dbz=%b",
                     e.dvd, e.dvs, quotient, remainder, div_by_zero, e.q, e.r, e.dbz);
        end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checks++;
            if (done !== 1'b0 || busy !== 1'b0 || quotient !== 8'd14 || remainder !== 8'd2) begin
                errors++;
                $display("FAIL basic_hold[%0d]: done=%b busy=%b q=%0d r=%0d required 0 0 14 2",
                         i, done, busy, quotient, remainder);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] a_tab[3] = '{8'd255, 8'd5, 8'd0};
        logic [7:0] b_tab[3] = '{8'd1, 8'd9, 8'd3};
        bit got; int lat; exp_t e;
        for (int i = 0; i < 3; i++) begin
            start_op(a_tab[i], b_tab[i]);
            wait_done(got, lat);
            e = sb.pop_front();
            checks++;
            if (!got || lat != 8) begin
                errors++;
                $display("FAIL b2b_latency[%0d]: got=%0d lat=%0d required 1 8", i, got, lat);
            end
            checks++;
            if (quotient !== e.q || remainder !== e.r || div_by_zero !== e.dbz) begin
                errors++;
                $display("FAIL b2b_result[%0d]: %0d/%0d gave q=%0d r=%0d dbz=%b required q=%0d r=%0d dbz=%b",
                         i, e.dvd, e.dvs, quotient, remainder, div_by_zero, e.q, e.r, e.dbz);
            end
            @(negedge clk);
            checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL b2b_pulse[%0d]: done=%b busy=%b required 0 0", i, done, busy);
            end
        end
    endtask

    task automatic test_div_zero();
        logic [7:0] a_tab[2] = '{8'd37, 8'd9};
        logic [7:0] b_tab[2] = '{8'd0, 8'd4};
        int lat_tab[2] = '{0, 8};
        bit got; int lat; exp_t e;
        for (int i = 0; i < 2; i++) begin
            start_op(a_tab[i], b_tab[i]);
            wait_done(got, lat);
            e = sb.pop_front();
            checks++;
            if (!got || lat != lat_tab[i]) begin
                errors++;
                $display("FAIL dz_latency[%0d]: got=%0d lat=%0d required 1 %0d", i, got, lat, lat_tab[i]);
            end
            checks++;
            if (quotient !== e.q || remainder !== e.r || div_by_zero !== e.dbz) begin
                errors++;
                $display("FAIL dz_result[%0d]: %0d/%0d gave q=%0d r=%0d dbz=%b required q=%0d r=%0d dbz=%b",
                         i, e.dvd, e.dvs, quotient, remainder, div_by_zero, e.q, e.r, e.dbz);
            end
            @(negedge clk);
            checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL dz_pulse[%0d]: done=%b busy=%b required 0 0", i, done, busy);
            end
        end
    endtask

    task automatic test_ignore_start();
        bit got; int lat; int extra; exp_t e;
        start_op(8'd200, 8'd3);
        repeat (2) @(negedge clk);
        start = 1'b1; dividend = 8'd50; divisor = 8'd5;
        @(negedge clk);
        start = 1'b0; dividend = 8'hAA; divisor = 8'h11;
        wait_done(got, lat);
        start = 1'b1; dividend = 8'd50; divisor = 8'd5;
        e = sb.pop_front();
        checks++;
        if (!got || lat != 8) begin
            errors++;
            $display("FAIL ignore_latency: got=%0d lat=%0d required 1 8", got, lat);
        end
        checks++;
        if (quotient !== 8'd66 || remainder !== 8'd2 || div_by_zero !== 1'b0) begin
            errors++;
            $display("FAIL ignore_result: q=%0d r=%0d dbz=%b required 66 2 0", quotient, remainder, div_by_zero);
        end
        @(negedge clk);
        start = 1'b0;
        extra = 0;
        repeat (12) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) extra++;
        end
        checks++;
        if (extra != 0 || quotient !== 8'd66 || remainder !== 8'd2) begin
            errors++;
            $display("FAIL ignore_no_second: active_cycles=%0d q=%0d r=%0d required 0 66 2", extra, quotient, remainder);
        end
    endtask

    task automatic test_abort();
        bit got; int lat; int extra; exp_t e;
        start_op(8'd200, 8'd3);
        e = sb.pop_back();
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL abort_flags: busy=%b done=%b required 0 0", busy, done);
        end
        checks++;
        if (quotient !== 8'd0 || remainder !== 8'd0 || div_by_zero !== 1'b0) begin
            errors++;
            $display("FAIL abort_data: q=%0d r=%0d dbz=%b required 0 0 0", quotient, remainder, div_by_zero);
        end
        start = 1'b1; dividend = 8'd10; divisor = 8'd3;
        extra = 0;
        repeat (12) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) extra++;
        end
        checks++;
        if (extra != 0) begin
            errors++;
            $display("FAIL abort_quiet: active_cycles=%0d required 0", extra);
        end
        rst = 1'b0;
        push_exp(8'd10, 8'd3);
        @(posedge clk);
        #1 accept_cyc = cyc;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL abort_restart_busy: busy=%b required 1", busy);
        end
        wait_done(got, lat);
        e = sb.pop_front();
        checks++;
        if (!got || lat != 8 || quotient !== e.q || remainder !== e.r || div_by_zero !== e.dbz) begin
            errors++;
            $display("FAIL abort_restart: got=%0d lat=%0d q=%0d r=%0d dbz=%b required 1 8 %0d %0d %b",
                     got, lat, quotient, remainder, div_by_zero, e.q, e.r, e.dbz);
        end
        @(negedge clk);
    endtask

    task automatic test_random();
        bit got; int lat; int exp_lat; exp_t e;
        logic [7:0] a, b;
        for (int i = 0; i < 502; i++) begin
            if (i == 0) begin
                a = 8'd255; b = 8'd255;
            end else if (i == 1) begin
                a = 8'd128; b = 8'd2;
            end else begin
                a = 8'($urandom_range(0, 255));
                b = 8'($urandom_range(0, 255));
            end
            start_op(a, b);
            wait_done(got, lat);
            e = sb.pop_front();
            exp_lat = (e.dvs == 8'd0) ? 0 : 8;
            checks++;
            if (!got || lat != exp_lat) begin
                errors++;
                $display("FAIL rand_latency[%0d]: %0d/%0d got=%0d lat=%0d required 1 %0d", i, a, b, got, lat, exp_lat);
            end
            checks++;
            if (quotient !== e.q || remainder !== e.r || div_by_zero !== e.dbz) begin
                errors++;
                $display("FAIL rand_result[%0d]: %0d/%0d gave q=%0d r=%0d dbz=%b required q=%0d r=%0d dbz=%b",
                         i, e.dvd, e.dvs, quotient, remainder, div_by_zero, e.q, e.r, e.dbz);
            end
            if (e.dvs != 8'd0) begin
                checks++;
                if (int'(quotient) * int'(e.dvs) + int'(remainder) != int'(e.dvd) || remainder >= e.dvs) begin
                    errors++;
                    $display("FAIL rand_invariant[%0d]: %0d/%0d gave q=%0d r=%0d", i, e.dvd, e.dvs, quotient, remainder);
                end
            end
            @(negedge clk);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_back_to_back();
        test_div_zero();
        test_ignore_start();
        test_abort();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
